// File: rtl/shift_reg_sequencer.sv
// Command sequencer for the shift-register datapath: clear, fill, load and
// normalize (load then shift left until the MSB is set, counting shifts).
module shift_reg_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  input  logic             reg_msb,
  input  logic             reg_is_zero,
  output logic             zero,
  output logic             init,
  output logic             ld,
  output logic             sh_en,
  output logic [WIDTH-1:0] r_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             result_zero
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_FILL    = 3'd2,
    S_LOAD    = 3'd3,
    S_N_LOAD  = 3'd4,
    S_N_SHIFT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           next_state_s;
  logic             capture_s;
  logic             sh_en_s;
  logic             set_rz_s;
  logic             zero_r;
  logic             init_r;
  logic             ld_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] r_in_r;
  logic [CNT_W-1:0] shift_cnt_r;
  logic             result_zero_r;

  // Next-state decode; sh_en must react to the live register value, so it stays combinational
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    sh_en_s      = 1'b0;
    set_rz_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          case (cmd)
            2'b00:   next_state_s = S_CLR;
            2'b01:   next_state_s = S_FILL;
            2'b10:   next_state_s = S_LOAD;
            default: next_state_s = S_N_LOAD;
          endcase
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CLR, S_FILL, S_LOAD: next_state_s = S_DONE;
      S_N_LOAD:              next_state_s = S_N_SHIFT;
      S_N_SHIFT: begin
        if (reg_is_zero) begin
          set_rz_s     = 1'b1;
          next_state_s = S_DONE;
        end else if (reg_msb) begin
          next_state_s = S_DONE;
        end else begin
          sh_en_s      = 1'b1;
          next_state_s = S_N_SHIFT;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register plus outputs registered from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      zero_r  <= 1'b0;
      init_r  <= 1'b0;
      ld_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      zero_r  <= (next_state_s == S_CLR);
      init_r  <= (next_state_s == S_FILL);
      ld_r    <= (next_state_s == S_LOAD) || (next_state_s == S_N_LOAD);
      busy_r  <= (next_state_s != S_IDLE);
      done_r  <= (next_state_s == S_DONE);
    end
  end

  // Operand capture and normalize result bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_r        <= {WIDTH{1'b0}};
      shift_cnt_r   <= {CNT_W{1'b0}};
      result_zero_r <= 1'b0;
    end else if (capture_s) begin
      r_in_r <= data_in;
      if (cmd == 2'b11) begin
        shift_cnt_r   <= {CNT_W{1'b0}};
        result_zero_r <= 1'b0;
      end else begin
        shift_cnt_r   <= shift_cnt_r;
        result_zero_r <= result_zero_r;
      end
    end else begin
      r_in_r <= r_in_r;
      // Saturating guard: the count can never legitimately wrap
      if (sh_en_s && (shift_cnt_r != CNT_MAX)) begin
        shift_cnt_r <= shift_cnt_r + CNT_ONE;
      end else begin
        shift_cnt_r <= shift_cnt_r;
      end
      result_zero_r <= result_zero_r | set_rz_s;
    end
  end

  assign zero        = zero_r;
  assign init        = init_r;
  assign ld          = ld_r;
  assign sh_en       = sh_en_s;
  assign r_in        = r_in_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign shift_cnt   = shift_cnt_r;
  assign result_zero = result_zero_r;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: models the 16-bit register, predicts every
// output per cycle from a transaction-level model, and runs directed + random commands.
module tb_shift_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] data_in = 16'h0000;
  logic        reg_msb, reg_is_zero;
  logic        zero, init, ld, sh_en, busy, done, result_zero;
  logic [15:0] r_in;
  logic [4:0]  shift_cnt;
  logic [15:0] sr = 16'h0000;

  int n_cmp = 0;
  int n_fail = 0;

  shift_reg_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .data_in(data_in),
    .reg_msb(reg_msb), .reg_is_zero(reg_is_zero),
    .zero(zero), .init(init), .ld(ld), .sh_en(sh_en), .r_in(r_in),
    .busy(busy), .done(done), .shift_cnt(shift_cnt), .result_zero(result_zero)
  );

  always #5 clk = ~clk;

  // The controlled register; deliberately not reset so it keeps its value
  always @(posedge clk) begin
    if (zero)       sr <= 16'h0000;
    else if (init)  sr <= 16'hFFFF;
    else if (ld)    sr <= r_in;
    else if (sh_en) sr <= {sr[14:0], 1'b0};
  end
  assign reg_msb     = sr[15];
  assign reg_is_zero = (sr == 16'h0000);

  function automatic int lead_zeros(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) return 15 - i;
    end
    return 0;
  endfunction

  // Transaction model: j counts cycles since acceptance (cycle T+j), m_end is the done offset
  logic        m_active;
  int          m_j, m_end, m_k;
  logic [1:0]  m_cmd;
  logic        m_zf;
  logic [15:0] m_op, m_exp_reg;
  int          last_cnt;
  logic        last_zf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_j <= 0; m_end <= 0; m_k <= 0; m_cmd <= 2'b00;
      m_zf <= 1'b0; m_op <= 16'h0000; m_exp_reg <= 16'h0000;
      last_cnt <= 0; last_zf <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_j      <= 1;
        m_cmd    <= cmd;
        m_op     <= data_in;
        if (cmd == 2'b11) begin
          m_k       <= lead_zeros(data_in);
          m_zf      <= (data_in == 16'h0000);
          m_end     <= 3 + lead_zeros(data_in);
          m_exp_reg <= data_in << lead_zeros(data_in);
          last_cnt  <= lead_zeros(data_in);
          last_zf   <= (data_in == 16'h0000);
        end else begin
          m_end     <= 2;
          m_exp_reg <= (cmd == 2'b00) ? 16'h0000 : (cmd == 2'b01) ? 16'hFFFF : data_in;
        end
      end
    end else if (m_j == m_end) begin
      m_active <= 1'b0;
    end else begin
      m_j <= m_j + 1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [27:0] act, exp_v;
    logic e_busy, e_done, e_zero, e_init, e_ld, e_sh, e_rz;
    int   e_cnt;
    if (rst) begin
      e_busy = m_active;
      e_done = m_active && (m_j == m_end);
      e_zero = m_active && (m_cmd == 2'b00) && (m_j == 1);
      e_init = m_active && (m_cmd == 2'b01) && (m_j == 1);
      e_ld   = m_active && m_cmd[1] && (m_j == 1);
      e_sh   = m_active && (m_cmd == 2'b11) && (m_j >= 2) && (m_j <= 1 + m_k);
      if (m_active && (m_cmd == 2'b11)) begin
        e_cnt = (m_j <= 1) ? 0 : (m_j <= 2 + m_k) ? (m_j - 2) : m_k;
        e_rz  = (m_j == m_end) ? m_zf : 1'b0;
      end else begin
        e_cnt = last_cnt;
        e_rz  = last_zf;
      end
      exp_v = {e_busy, e_done, e_zero, e_init, e_ld, e_sh, e_rz, 5'(e_cnt), m_op};
      act   = {busy, done, zero, init, ld, sh_en, result_zero, shift_cnt, r_in};
      n_cmp++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got %h expected %h (busy,done,zero,init,ld,sh_en,rz,cnt,r_in)",
                 $time, act, exp_v);
      end
      if (e_done) begin
        n_cmp++;
        if (sr !== m_exp_reg) begin
          n_fail++;
          $display("FAIL register_at_done t=%0t got %h expected %h", $time, sr, m_exp_reg);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 50) begin @(negedge clk); g++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
  endtask

  // Issue one command from IDLE and check latency/results against hand-computed literals
  task automatic run_cmd(input logic [1:0] c, input logic [15:0] d, input int exp_lat,
                         input int exp_cnt, input logic exp_rz, input logic [15:0] exp_reg,
                         input string nm);
    int n;
    wait_idle();
    start = 1'b1; cmd = c; data_in = d;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_shift_cnt"}, 32'(shift_cnt), 32'(exp_cnt));
    chk({nm, "_result_zero"}, 32'(result_zero), 32'(exp_rz));
    chk({nm, "_register"}, 32'(sr), 32'(exp_reg));
  endtask

  initial begin
    int n;
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({zero, init, ld, sh_en, busy, done, result_zero, shift_cnt, r_in}), 32'd0);
    rst = 1'b1;

    run_cmd(2'b00, 16'h1234, 2, 0, 1'b0, 16'h0000, "clear");
    run_cmd(2'b01, 16'h0000, 2, 0, 1'b0, 16'hFFFF, "fill");
    run_cmd(2'b10, 16'hA5A5, 2, 0, 1'b0, 16'hA5A5, "load");
    run_cmd(2'b11, 16'h0001, 18, 15, 1'b0, 16'h8000, "norm_0001");
    run_cmd(2'b10, 16'h0F0F, 2, 15, 1'b0, 16'h0F0F, "load_keeps_cnt");
    run_cmd(2'b11, 16'h8000, 3, 0, 1'b0, 16'h8000, "norm_8000");
    run_cmd(2'b11, 16'h0F00, 7, 4, 1'b0, 16'hF000, "norm_0F00");
    run_cmd(2'b11, 16'h0000, 3, 0, 1'b1, 16'h0000, "norm_zero");

    // Start held high across a normalize: ignored until the cycle after done
    wait_idle();
    start = 1'b1; cmd = 2'b11; data_in = 16'h0001;
    @(negedge clk);
    cmd = 2'b00;
    wait_done(n);
    chk("held_norm_latency", 32'(n), 32'd18);
    chk("held_norm_cnt", 32'(shift_cnt), 32'd15);
    @(negedge clk);
    chk("held_idle_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held_clear_accepted", 32'(zero), 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("held_clear_latency", 32'(n), 32'd2);

    // Asynchronous reset after five shifts of a normalize
    wait_idle();
    start = 1'b1; cmd = 2'b11; data_in = 16'h0001;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_outputs", 32'({zero, init, ld, sh_en, busy, done, result_zero, shift_cnt, r_in}), 32'd0);
    chk("abort_register", 32'(sr), 32'h0020);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    rst = 1'b1;
    run_cmd(2'b10, 16'h5A5A, 2, 0, 1'b0, 16'h5A5A, "post_reset_load");

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      cmd   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       data_in = 16'h0000;
        1:       data_in = 16'h0001 << $urandom_range(0, 15);
        2:       data_in = 16'($urandom);
        default: data_in = 16'($urandom) >> $urandom_range(0, 15);
      endcase
    end
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command sequencer for the 16-bit shift register datapath: it accepts one command at a time and drives the register's `zero`/`init`/`ld`/`sh_en` controls and its load data. Supported commands are clear, fill-with-ones, load and normalize. Normalize loads a word, then shifts it left until bit WIDTH-1 is set, reporting the shift count. The block sits between the lab-level control logic (start/done handshake) and the register, which it observes through its MSB and zero-detect.

## Interface
- `WIDTH`, 16, register width
- `CNT_W`, 5, shift-count width; must satisfy 2^CNT_W > WIDTH-1
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-low reset
- `start`  input  1  command request; sampled only in IDLE
- `cmd`  input  2  command code: 00 clear, 01 fill, 10 load, 11 normalize
- `data_in`  input  WIDTH  operand for load/normalize, captured when start is accepted
- `reg_msb`  input  1  register bit WIDTH-1
- `reg_is_zero`  input  1  high when the register value is all zeros
- `zero`, `init`, `ld`, `sh_en`  output  1 each  register controls
- `r_in`  output  WIDTH  held operand, driven to the register load port
- `busy`  output  1  high whenever state is not IDLE
- `done`  output  1  one-cycle completion pulse
- `shift_cnt`  output  CNT_W  shifts performed by the last normalize
- `result_zero`  output  1  last normalize found an all-zero operand

## Operation
- States: IDLE, CLR, FILL, LOAD, N_LOAD, N_SHIFT, DONE.
- IDLE:
  - `start`=1 captures `cmd` and `data_in` (into `r_in`).
  - Next state by `cmd`: CLR / FILL / LOAD / N_LOAD.
  - Normalize also clears `shift_cnt` and `result_zero`.
  - Clear, fill and load leave `shift_cnt`/`result_zero` unchanged.
- CLR: `zero`=1, then go to DONE.
- FILL: `init`=1, then go to DONE.
- LOAD: `ld`=1, then go to DONE.
- N_LOAD: `ld`=1, then go to N_SHIFT.
- N_SHIFT, evaluated each cycle on the register's current value:
  - `reg_is_zero`=1: `result_zero`<=1, go to DONE, no shift.
  - Else `reg_msb`=1: go to DONE, no shift.
  - Else: `sh_en`=1, `shift_cnt`<=`shift_cnt`+1, stay in N_SHIFT.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored: not queued, no effect.
- Control outputs are one-hot-or-zero: never two of `zero`/`init`/`ld`/`sh_en` high in the same cycle. All four are 0 in IDLE and DONE.
- The maximum count is WIDTH-1 (operand 1); `shift_cnt` never wraps.
- `r_in` holds its value between commands.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE.
  - `zero`=`init`=`ld`=`sh_en`=0, `busy`=0, `done`=0.
  - `r_in`=0, `shift_cnt`=0, `result_zero`=0.
  - Reset mid-command aborts it with no `done`. The register keeps whatever value the last completed edge gave it.
- Start accepted at the edge ending cycle T (IDLE, `start`=1):
  - Clear/fill/load: control high in T+1, `done` in T+2, IDLE (ready) in T+3. `busy`=1 in T+1..T+2.
  - Normalize with k required shifts: `ld` in T+1, N_SHIFT for T+2..T+2+k (`sh_en` in the first k of those cycles), `done` in T+3+k.
  - Normalize outputs `shift_cnt`=k and `result_zero` are valid from the `done` cycle and held until the next normalize is accepted.
- Back-to-back: `start` held high during the `done` cycle is ignored. It is accepted in the first IDLE cycle after `done`.
- `reg_msb`/`reg_is_zero` are used combinationally in N_SHIFT. The register updates on the same edge the sequencer advances, so the controls are one cycle ahead of their effect.

## Test plan
- Reset, then clear: `cmd`=00 -> `zero` high exactly 1 cycle (T+1), `done` at T+2, register 0x0000. Then fill `cmd`=01 -> `init` at T+1, register 0xFFFF.
- Load: `cmd`=10, `data_in`=0xA5A5 -> `ld` at T+1, register 0xA5A5, `done` at T+2, `shift_cnt` unchanged.
- Normalize 0x0001 -> 15 `sh_en` cycles, register 0x8000, `shift_cnt`=15, `result_zero`=0, `done` at T+18. Normalize 0x8000 -> `shift_cnt`=0, `done` at T+3. Normalize 0x0F00 -> `shift_cnt`=4, register 0xF000.
- Normalize 0x0000 -> no `sh_en`, `result_zero`=1, `shift_cnt`=0, `done` at T+3.
- Start held high while busy on normalize 0x0001 with `cmd`=00 -> no `zero` pulse, result unaffected. Start (still high) is accepted in the cycle after `done`.
- `rst` low during N_SHIFT of normalize 0x0001 (after 5 shifts) -> all outputs 0 immediately, no `done`, register holds 0x0020. A new command after reset release executes normally.
